// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with x0 hard-wired to zero, optional write bypass and per-register busy scoreboard
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    output logic [XLEN-1:0]   Data1,
    output logic [XLEN-1:0]   Data2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [XLEN-1:0]   WriteData,
    input  logic              AllocValid,
    input  logic [ADDR_W-1:0] AllocReg,
    output logic              AnyBusy
);
    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  rd1, rd2;
    logic             bz1, bz2;
    logic             wr_ok, al_ok, al_same, byp1, byp2;

    assign wr_ok   = RegWrite && WriteReg != '0 && 32'(WriteReg) < NREGS;
    assign al_ok   = AllocValid && AllocReg != '0 && 32'(AllocReg) < NREGS;
    assign al_same = al_ok && AllocReg == WriteReg;
    assign byp1    = BYPASS != 0 && wr_ok && WriteReg == Read1;
    assign byp2    = BYPASS != 0 && wr_ok && WriteReg == Read2;
    assign Data1   = byp1 ? WriteData : rd1;
    assign Data2   = byp2 ? WriteData : rd2;
    assign Busy1   = byp1 ? al_same && bz1 : bz1;
    assign Busy2   = byp2 ? al_same && bz2 : bz2;
    assign AnyBusy = |busy_q;

    // read mux: x0 and out-of-range numbers never match, so they read as zero and not busy
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        bz1 = 1'b0;
        bz2 = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (32'(Read1) == i) begin
                rd1 = rf_q[i];
                bz1 = busy_q[i];
            end
            if (32'(Read2) == i) begin
                rd2 = rf_q[i];
                bz2 = busy_q[i];
            end
        end
    end

    // next state: writeback clears busy, then a same-register alloc re-sets it
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_ok && 32'(WriteReg) == i) begin
                rf_d[i]   = WriteData;
                busy_d[i] = 1'b0;
            end
            if (al_ok && 32'(AllocReg) == i) busy_d[i] = 1'b1;
        end
    end

    // state register with synchronous clear of data and scoreboard
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end
endmodule
